// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: access-size codes,
// FSM state encoding, latency counter width and the alignment check.
package mem_access_pkg;

    localparam logic [1:0] MASK_B = 2'b00;
    localparam logic [1:0] MASK_H = 2'b01;
    localparam logic [1:0] MASK_W = 2'b10;

    // Wide enough for read latencies up to 7.
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // True for an illegal size code or an address not aligned to the size.
    function automatic logic is_misaligned(input logic [1:0] mask, input logic [1:0] off);
        logic bad;
        case (mask)
            MASK_B:  bad = 1'b0;
            MASK_H:  bad = off[0];
            MASK_W:  bad = |off;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Picks the addressed byte/half lane out of a RAM word and sign- or
// zero-extends it. Word accesses pass through and ignore the sign flag.
module load_extract
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  mask_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension according to the access size.
    always_comb begin
        byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (mask_i)
            MASK_B:  data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
            MASK_H:  data_o = {{16{sign_i & half_sel[15]}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store responder between the CPU data port and a
// word-wide synchronous RAM with per-byte write enables.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a request; misaligned ones go straight to RESP
// ST_ISSUE | one-cycle RAM strobe (write for stores, read for loads)
// ST_WAIT  | counting down the RAM read latency, sample data at count 1
// ST_RESP  | one-cycle response strobe, then back to IDLE
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_mask_i,
    input  logic              req_sign_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [1:0]         mask_q, mask_d;
    logic               sign_q, sign_d;
    logic [ADDR_W+1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic               mem_en_raw;
    logic [3:0]         mem_we_raw;
    logic [31:0]        ext_data;

    // Address bits above the RAM size are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[31:ADDR_W+2];

    load_extract u_load_extract (
        .rdata_i (mem_rdata_i),
        .addr_i  (addr_q[1:0]),
        .mask_i  (mask_q),
        .sign_i  (sign_q),
        .data_o  (ext_data)
    );

    // Next-state, request latching and RAM/response output decode.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        mask_d      = mask_q;
        sign_d      = sign_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_en_raw  = 1'b0;
        mem_we_raw  = 4'b0000;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        req_ready_o = (state_q == ST_IDLE);
        rsp_valid_o = (state_q == ST_RESP);

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    mask_d  = req_mask_i;
                    sign_d  = req_sign_i;
                    addr_d  = req_addr_i[ADDR_W+1:0];
                    wdata_d = req_wdata_i;
                    if (is_misaligned(req_mask_i, req_addr_i[1:0])) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                mem_en_raw = 1'b1;
                mem_addr_o = addr_q[ADDR_W+1:2];
                if (we_q) begin
                    case (mask_q)
                        MASK_B: begin
                            mem_we_raw  = 4'b0001 << addr_q[1:0];
                            mem_wdata_o = {4{wdata_q[7:0]}};
                        end
                        MASK_H: begin
                            mem_we_raw  = 4'b0011 << addr_q[1:0];
                            mem_wdata_o = {2{wdata_q[15:0]}};
                        end
                        default: begin
                            mem_we_raw  = 4'b1111;
                            mem_wdata_o = wdata_q;
                        end
                    endcase
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    rsp_rdata_d = ext_data;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM strobes are gated by reset so a reset landing in ISSUE writes nothing.
    assign mem_en_o    = mem_en_raw & ~rst_i;
    assign mem_we_o    = mem_we_raw & {4{~rst_i}};
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    // State and latched request registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            mask_q      <= 2'b00;
            sign_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            mask_q      <= mask_d;
            sign_q      <= sign_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (read latency 1 and 3), each
// with its own RAM model, checked every cycle against a transaction model.
module tb_mem_access_unit;

    localparam int AW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst       [2];
    logic          req_valid [2];
    logic          req_ready [2];
    logic          req_we    [2];
    logic [1:0]    req_mask  [2];
    logic          req_sign  [2];
    logic [31:0]   req_addr  [2];
    logic [31:0]   req_wdata [2];
    logic          rsp_valid [2];
    logic [31:0]   rsp_rdata [2];
    logic          rsp_err   [2];
    logic          mem_en    [2];
    logic [3:0]    mem_we    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [31:0]   mem_wdata [2];
    logic [31:0]   mem_rdata [2];

    mem_access_unit #(.ADDR_W(AW), .RD_LAT(1)) dut0 (
        .clk_i(clk), .rst_i(rst[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_we_i(req_we[0]), .req_mask_i(req_mask[0]), .req_sign_i(req_sign[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]),
        .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
        .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0])
    );

    mem_access_unit #(.ADDR_W(AW), .RD_LAT(3)) dut1 (
        .clk_i(clk), .rst_i(rst[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_we_i(req_we[1]), .req_mask_i(req_mask[1]), .req_sign_i(req_sign[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]),
        .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
        .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // RAM models: byte-enable writes, reads delivered through a latency pipe.
    logic [31:0] ram  [2][64];
    logic [31:0] pipe [2][3];
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int d = 0; d < 2; d++)
                for (int w = 0; w < 64; w++)
                    ram[d][w] <= 32'h0BAD0000 | 32'(w);
            ram[0][1] <= 32'h12F45678;
            ram[1][0] <= 32'h80010000;
            ram[1][3] <= 32'h807F00FF;
        end else begin
            for (int d = 0; d < 2; d++)
                for (int b = 0; b < 4; b++)
                    if (mem_en[d] && mem_we[d][b])
                        ram[d][mem_addr[d]][8*b +: 8] <= mem_wdata[d][8*b +: 8];
        end
        for (int d = 0; d < 2; d++) begin
            pipe[d][0] <= (mem_en[d] && mem_we[d] == 4'b0000) ? ram[d][mem_addr[d]] : 32'hDEADBEEF;
            pipe[d][1] <= pipe[d][0];
            pipe[d][2] <= pipe[d][1];
        end
    end
    assign mem_rdata[0] = pipe[0][0];
    assign mem_rdata[1] = pipe[1][2];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Load result from the addressed bytes of a word using plain arithmetic.
    function automatic logic [31:0] model_load(input logic [31:0] w, input int off,
                                               input int sz, input bit sgn);
        longint v, m;
        v = longint'(w) >> (8 * off);
        m = longint'(1) << (8 * sz);
        if (sz < 4) begin
            v = v % m;
            if (sgn && v >= m / 2) v = v - m;
        end
        return v[31:0];
    endfunction

    // Transaction model state and observed values for literal checks.
    bit            pend     [2];
    int            due      [2];
    int            acc_edge [2];
    int            iss      [2];
    logic          exp_err  [2];
    logic [31:0]   exp_rd   [2];
    logic [31:0]   hold_rd  [2];
    logic          hold_err [2];
    logic          exp_st   [2];
    logic [3:0]    exp_be   [2];
    logic [31:0]   exp_wd   [2];
    logic [AW-1:0] exp_ma   [2];
    logic [31:0]   obs_rd   [2];
    logic          obs_err  [2];
    int            obs_lat  [2];
    logic [3:0]    obs_we   [2];
    logic [31:0]   obs_wd   [2];
    logic [AW-1:0] obs_ma   [2];
    int            seen_rsp [2];

    // Single compare process: every cycle, both instances against the model.
    always @(negedge clk) begin
        int  off, sz, lat;
        bit  err, ready_exp;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                chk("rst_gate_mem_en", 32'(mem_en[d]), 32'd0);
                chk("rst_gate_mem_we", 32'(mem_we[d]), 32'd0);
                pend[d] = 1'b0;
                iss[d] = -1;
                hold_rd[d] = '0;
                hold_err[d] = 1'b0;
            end else begin
                ready_exp = !pend[d];
                chk("req_ready", 32'(req_ready[d]), 32'(ready_exp));
                if (rsp_valid[d]) seen_rsp[d]++;
                if (pend[d] && due[d] == cyc) begin
                    chk("rsp_valid", 32'(rsp_valid[d]), 32'd1);
                    chk("rsp_err", 32'(rsp_err[d]), 32'(exp_err[d]));
                    chk("rsp_rdata", rsp_rdata[d], exp_rd[d]);
                    obs_rd[d] = rsp_rdata[d];
                    obs_err[d] = rsp_err[d];
                    obs_lat[d] = cyc - acc_edge[d] + 1;
                    hold_rd[d] = exp_rd[d];
                    hold_err[d] = exp_err[d];
                    pend[d] = 1'b0;
                end else begin
                    chk("rsp_valid_idle", 32'(rsp_valid[d]), 32'd0);
                    chk("rsp_rdata_hold", rsp_rdata[d], hold_rd[d]);
                    chk("rsp_err_hold", 32'(rsp_err[d]), 32'(hold_err[d]));
                end
                if (iss[d] == cyc) begin
                    chk("issue_mem_en", 32'(mem_en[d]), 32'd1);
                    chk("issue_mem_addr", 32'(mem_addr[d]), 32'(exp_ma[d]));
                    chk("issue_mem_we", 32'(mem_we[d]), 32'(exp_be[d]));
                    if (exp_st[d]) chk("issue_mem_wdata", mem_wdata[d], exp_wd[d]);
                    obs_we[d] = mem_we[d];
                    obs_wd[d] = mem_wdata[d];
                    obs_ma[d] = mem_addr[d];
                    iss[d] = -1;
                end else begin
                    chk("mem_en_idle", 32'(mem_en[d]), 32'd0);
                    chk("mem_we_idle", 32'(mem_we[d]), 32'd0);
                end
                if (ready_exp && req_valid[d]) begin
                    off = int'(req_addr[d][1:0]);
                    case (req_mask[d])
                        2'b00:   sz = 1;
                        2'b01:   sz = 2;
                        2'b10:   sz = 4;
                        default: sz = 0;
                    endcase
                    err = (sz == 0) ? 1'b1 : ((off % sz) != 0);
                    lat = err ? 1 : (req_we[d] ? 2 : 2 + lat_of(d));
                    pend[d] = 1'b1;
                    acc_edge[d] = cyc + 1;
                    due[d] = cyc + lat;
                    exp_err[d] = err;
                    exp_rd[d] = (err || req_we[d]) ? 32'd0 :
                                model_load(ram[d][req_addr[d][AW+1:2]], off, sz, req_sign[d]);
                    if (!err) begin
                        iss[d] = cyc + 1;
                        exp_st[d] = req_we[d];
                        exp_ma[d] = req_addr[d][AW+1:2];
                        for (int b = 0; b < 4; b++) begin
                            exp_be[d][b] = req_we[d] && b >= off && b < off + sz;
                            exp_wd[d][8*b +: 8] = req_wdata[d][8*(b % sz) +: 8];
                        end
                    end
                end
            end
        end
    end

    // Present a request and hold it until the handshake edge; valid stays high.
    task automatic send(input int d, input bit we, input logic [1:0] mask, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
        bit ok;
        req_we[d] = we;
        req_mask[d] = mask;
        req_sign[d] = sgn;
        req_addr[d] = addr;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[d] && !rst[d]) ok = 1'b1;
        end
        chk("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d);
        for (int i = 0; i < 40 && pend[d]; i++) @(posedge clk);
        chk("rsp_timeout", 32'(pend[d]), 32'd0);
        #1;
    endtask

    task automatic txn(input int d, input bit we, input logic [1:0] mask, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
        send(d, we, mask, sgn, addr, wdata);
        req_valid[d] = 1'b0;
        wait_done(d);
    endtask

    int a1, a2, n_before;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            req_valid[d] = 1'b0;
            req_we[d] = 1'b0;
            req_mask[d] = 2'b00;
            req_sign[d] = 1'b0;
            req_addr[d] = '0;
            req_wdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", 32'(req_ready[d]), 32'd1);
            chk("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("reset_rsp_rdata", rsp_rdata[d], 32'd0);
            chk("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
            chk("reset_mem_en", 32'(mem_en[d]), 32'd0);
            chk("reset_mem_we", 32'(mem_we[d]), 32'd0);
            chk("reset_mem_addr", 32'(mem_addr[d]), 32'd0);
            chk("reset_mem_wdata", mem_wdata[d], 32'd0);
        end
        @(posedge clk);
        #1;

        // Byte loads, latency 1
        txn(0, 1'b0, 2'b00, 1'b1, 32'h0000_0006, 32'h0);
        chk("lb_signed_data", obs_rd[0], 32'hFFFF_FFF4);
        chk("lb_signed_lat", 32'(obs_lat[0]), 32'd3);
        txn(0, 1'b0, 2'b00, 1'b0, 32'h0000_0006, 32'h0);
        chk("lb_unsigned_data", obs_rd[0], 32'h0000_00F4);

        // Byte store, then read the whole word back
        txn(0, 1'b1, 2'b00, 1'b0, 32'h0000_0006, 32'h0000_00A5);
        chk("sb_we", 32'(obs_we[0]), 32'h4);
        chk("sb_wdata", obs_wd[0], 32'hA5A5_A5A5);
        chk("sb_addr", 32'(obs_ma[0]), 32'd1);
        chk("sb_lat", 32'(obs_lat[0]), 32'd2);
        chk("sb_err", 32'(obs_err[0]), 32'd0);
        txn(0, 1'b0, 2'b10, 1'b1, 32'h0000_0004, 32'h0);
        chk("lw_after_sb", obs_rd[0], 32'h12A5_5678);

        // Half store at upper lane and read back unsigned
        txn(0, 1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h0000_1234);
        chk("sh_we", 32'(obs_we[0]), 32'hC);
        chk("sh_wdata", obs_wd[0], 32'h1234_1234);
        txn(0, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0);
        chk("lh_after_sh", obs_rd[0], 32'h0000_1234);

        // Half loads, latency 3
        txn(1, 1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0);
        chk("lh_signed_data", obs_rd[1], 32'hFFFF_8001);
        chk("lh_signed_lat", 32'(obs_lat[1]), 32'd5);
        txn(1, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0);
        chk("lh_unsigned_data", obs_rd[1], 32'h0000_8001);

        // Misaligned and illegal requests
        txn(1, 1'b0, 2'b10, 1'b0, 32'h0000_0005, 32'h0);
        chk("err_lw_flag", 32'(obs_err[1]), 32'd1);
        chk("err_lw_data", obs_rd[1], 32'd0);
        chk("err_lw_lat", 32'(obs_lat[1]), 32'd1);
        txn(1, 1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
        chk("err_mask11_flag", 32'(obs_err[1]), 32'd1);
        txn(1, 1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'hFFFF_FFFF);
        chk("err_sh_flag", 32'(obs_err[1]), 32'd1);

        // Lane/sign variety, latency 3
        txn(1, 1'b0, 2'b00, 1'b1, 32'h0000_000E, 32'h0);
        chk("lb_pos_signed", obs_rd[1], 32'h0000_007F);
        txn(1, 1'b0, 2'b00, 1'b1, 32'h0000_000F, 32'h0);
        chk("lb_lane3_signed", obs_rd[1], 32'hFFFF_FF80);
        txn(1, 1'b0, 2'b10, 1'b1, 32'h0000_000C, 32'h0);
        chk("lw_ignores_sign", obs_rd[1], 32'h807F_00FF);
        txn(1, 1'b0, 2'b01, 1'b1, 32'h0000_000E, 32'h0);
        chk("lh_hi_signed", obs_rd[1], 32'hFFFF_807F);

        // Back-to-back with valid held high; upper address bits ignored
        send(0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hCAFE_BABE);
        a1 = acc_edge[0];
        send(0, 1'b0, 2'b10, 1'b0, 32'hFFFF_FF10, 32'h0);
        a2 = acc_edge[0];
        req_valid[0] = 1'b0;
        wait_done(0);
        chk("b2b_accept_gap", 32'(a2 - a1), 32'd3);
        chk("b2b_load_data", obs_rd[0], 32'hCAFE_BABE);
        chk("b2b_load_lat", 32'(obs_lat[0]), 32'd3);

        // Reset landing in ISSUE of a word store
        n_before = seen_rsp[0];
        send(0, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h55AA_55AA);
        req_valid[0] = 1'b0;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        chk("rst_issue_ram", ram[0][8], 32'h0BAD_0008);
        @(negedge clk);
        chk("rst_issue_ready", 32'(req_ready[0]), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_issue_no_rsp", 32'(seen_rsp[0]), 32'(n_before));

        // Reset in the middle of a load's wait
        n_before = seen_rsp[1];
        send(1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0);
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midload_no_rsp", 32'(seen_rsp[1]), 32'(n_before));
        txn(1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0);
        chk("after_midload_data", obs_rd[1], 32'h8001_0000);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
